instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of entries; power of 2, >= 2.
REQ-002 SHALL have parameter OP_WIDTH, default 32, signed operand width.
REQ-003 SHALL have parameter RES_WIDTH, default 2*OP_WIDTH, signed result width; >= 2*OP_WIDTH.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports named clk and reset_n.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port load_en  input  1  push request.
REQ-008 SHALL have port opcode  input  opcode_t  operation to store.
REQ-009 SHALL have port operand_a  input  OP_WIDTH  signed operand A.
REQ-010 SHALL have port operand_b  input  OP_WIDTH  signed operand B.
REQ-011 SHALL have port rd_en  input  1  pop request.
REQ-012 SHALL have port instruction_word  output  entry  head entry {opc, op_a, op_b, result, err}.
REQ-013 SHALL have port valid_out  output  1  head entry valid (not empty).
REQ-014 SHALL have port full  output  1  DEPTH entries held.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  entries held.
REQ-016 SHALL have port drop_cnt  output  16  rejected pushes, saturating.

Function
REQ-017 SHALL accept a push on a rising clk edge when load_en=1 and (full=0 or rd_en=1).
REQ-018 SHALL compute result at push time, sign-extended to RES_WIDTH: ZERO->0, PASSA->a, PASSB->b, ADD->a+b, SUB->a-b, MULT->a*b full product, DIV->a/b truncated toward zero, MOD->a%b with the sign of a.
REQ-019 SHALL, for DIV or MOD with b=0, store result 0 and err=1; all other valid opcodes store err=0.
REQ-020 SHALL, for an opcode outside opcode_t, store opc=ZERO, operands 0, result 0, err=1.
REQ-021 SHALL present the head entry combinationally on instruction_word (first-word fall-through, 0-cycle read latency).
REQ-022 SHALL drive instruction_word to all zeros with opc=ZERO while empty.
REQ-023 SHALL pop on a rising edge when rd_en=1 and valid_out=1; rd_en while empty is ignored.
REQ-024 SHALL, on simultaneous push and pop while full, perform both; count stays DEPTH.
REQ-025 SHALL, on simultaneous push and pop while empty, accept the push only; count becomes 1.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL increment drop_cnt when load_en=1, full=1, rd_en=0, saturating at 16'hFFFF; the rejected push leaves storage unchanged.
REQ-028 SHALL update count, full and valid_out in the same edge as the push/pop.

Reset
REQ-029 SHALL, while reset_n=0, clear all entries to opc=ZERO/all-zero, pointers to 0, count to 0, drop_cnt to 0, full to 0 and valid_out to 0, independent of clk.
REQ-030 SHALL, on reset assertion mid-operation, discard all stored entries; the first edge after release behaves as empty.

Structure
REQ-031 SHALL take opcode_t, the entry field order and default parameter constants from the shared instr_register_pkg; parametrised entry struct is declared inside the module.
REQ-032 SHALL place result/err computation in a combinational sub-module instr_alu, parametrised by OP_WIDTH and RES_WIDTH.

Verification
REQ-033 SHALL verify: reset, push ADD a=5 b=-7 -> next cycle valid_out=1, result=-2, err=0, count=1.
REQ-034 SHALL verify: push MULT a=32'h7FFFFFFF b=2 -> result=64'h00000000FFFFFFFE, err=0.
REQ-035 SHALL verify: push DIV a=9 b=0, then MOD a=-7 b=2 -> results 0/err=1, then -1/err=0, popped in order.
REQ-036 SHALL verify: DEPTH+3 pushes with rd_en=0 -> full=1, count=DEPTH, drop_cnt=3, first DEPTH entries intact.
REQ-037 SHALL verify: full, push+pop same cycle -> count stays DEPTH, head advances, new entry at tail; across 2*DEPTH pushes/pops order is preserved through pointer wrap.
REQ-038 SHALL verify: reset_n low between clock edges with 4 entries -> instruction_word immediately zero, valid_out=0, count=0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared opcode encoding, entry field order and default sizing for the instruction queue.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   localparam int OPC_W            = $bits(opcode_t);
   localparam int DEFAULT_DEPTH    = 32;
   localparam int DEFAULT_OP_WIDTH = 32;

   // The 4-bit encoding leaves codes 8..15 unassigned; those are treated as illegal.
   function automatic logic opcode_legal(input logic [OPC_W-1:0] code);
      return code <= MOD;
   endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational result/error computation for one queued instruction.
module instr_alu
   import instr_register_pkg::*;
#(
   parameter int OP_WIDTH  = DEFAULT_OP_WIDTH,
   parameter int RES_WIDTH = 2*OP_WIDTH
) (
   input  opcode_t                     opc,
   input  logic signed [OP_WIDTH-1:0]  a,
   input  logic signed [OP_WIDTH-1:0]  b,
   output logic signed [RES_WIDTH-1:0] result,
   output logic                        err
);

   logic signed [RES_WIDTH-1:0] a_ext;
   logic signed [RES_WIDTH-1:0] b_ext;
   logic signed [RES_WIDTH-1:0] b_div;
   logic                        b_zero;

   // Working at RES_WIDTH keeps MULT exact and MIN/-1 division free of overflow.
   assign a_ext  = {{(RES_WIDTH-OP_WIDTH){a[OP_WIDTH-1]}}, a};
   assign b_ext  = {{(RES_WIDTH-OP_WIDTH){b[OP_WIDTH-1]}}, b};
   assign b_zero = (b == '0);
   assign b_div  = b_zero ? {{(RES_WIDTH-1){1'b0}}, 1'b1} : b_ext;

   always_comb begin
      result = '0;
      err    = 1'b0;
      case (opc)
         ZERO:  result = '0;
         PASSA: result = a_ext;
         PASSB: result = b_ext;
         ADD:   result = a_ext + b_ext;
         SUB:   result = a_ext - b_ext;
         MULT:  result = a_ext * b_ext;
         DIV: begin
            if (b_zero) err = 1'b1;
            else        result = a_ext / b_div;
         end
         MOD: begin
            if (b_zero) err = 1'b1;
            else        result = a_ext % b_div;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_queue.sv
// First-word fall-through instruction FIFO; each entry carries its result computed at push time.
module instr_queue
   import instr_register_pkg::*;
#(
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int OP_WIDTH  = DEFAULT_OP_WIDTH,
   parameter int RES_WIDTH = 2*OP_WIDTH
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic                                     load_en,
   input  opcode_t                                  opcode,
   input  logic signed [OP_WIDTH-1:0]               operand_a,
   input  logic signed [OP_WIDTH-1:0]               operand_b,
   input  logic                                     rd_en,
   output logic [OPC_W+2*OP_WIDTH+RES_WIDTH:0]      instruction_word,
   output logic                                     valid_out,
   output logic                                     full,
   output logic [$clog2(DEPTH):0]                   count,
   output logic [15:0]                              drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = DEPTH;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;

   typedef struct packed {
      opcode_t                     opc;
      logic signed [OP_WIDTH-1:0]  op_a;
      logic signed [OP_WIDTH-1:0]  op_b;
      logic signed [RES_WIDTH-1:0] result;
      logic                        err;
   } entry_t;

   entry_t                      mem [DEPTH];
   entry_t                      new_entry;
   logic [PTR_W-1:0]            wr_ptr;
   logic [PTR_W-1:0]            rd_ptr;
   logic signed [RES_WIDTH-1:0] alu_result;
   logic                        alu_err;
   logic                        do_push;
   logic                        do_pop;
   logic                        drop;

   instr_alu #(
      .OP_WIDTH  (OP_WIDTH),
      .RES_WIDTH (RES_WIDTH)
   ) u_alu (
      .opc    (opcode),
      .a      (operand_a),
      .b      (operand_b),
      .result (alu_result),
      .err    (alu_err)
   );

   // Illegal opcodes are stored sanitised: ZERO with cleared operands, err from the ALU.
   always_comb begin
      new_entry = '0;
      if (opcode_legal(opcode)) begin
         new_entry.opc  = opcode;
         new_entry.op_a = operand_a;
         new_entry.op_b = operand_b;
      end
      new_entry.result = alu_result;
      new_entry.err    = alu_err;
   end

   assign full      = (count == FULL_CNT);
   assign valid_out = (count != '0);
   assign do_pop    = rd_en && valid_out;
   assign do_push   = load_en && (!full || rd_en);
   assign drop      = load_en && full && !rd_en;

   assign instruction_word = valid_out ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= new_entry;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// Directed scoreboard bench for instr_queue with default parameters.
module tb_instr_queue;
   import instr_register_pkg::*;

   localparam int DEPTH = 32;
   localparam int EW    = 4 + 32 + 32 + 64 + 1;

   typedef struct packed {
      logic [3:0]         opc;
      logic signed [31:0] a;
      logic signed [31:0] b;
      logic signed [63:0] res;
      logic               err;
   } tb_entry_t;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               load_en;
   opcode_t            opcode;
   logic signed [31:0] operand_a;
   logic signed [31:0] operand_b;
   logic               rd_en;
   logic [EW-1:0]      instruction_word;
   logic               valid_out;
   logic               full;
   logic [5:0]         count;
   logic [15:0]        drop_cnt;

   tb_entry_t sb[$];
   int        mcount;
   int        mdrop;
   int        passed;
   int        total;
   tb_entry_t h;

   always #5 clk = ~clk;

   instr_queue dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .load_en          (load_en),
      .opcode           (opcode),
      .operand_a        (operand_a),
      .operand_b        (operand_b),
      .rd_en            (rd_en),
      .instruction_word (instruction_word),
      .valid_out        (valid_out),
      .full             (full),
      .count            (count),
      .drop_cnt         (drop_cnt)
   );

   function automatic tb_entry_t model(input logic [3:0] opc, input logic signed [31:0] a,
                                       input logic signed [31:0] b);
      tb_entry_t e;
      longint    la = a;
      longint    lb = b;
      e     = '0;
      e.opc = opc;
      e.a   = a;
      e.b   = b;
      case (opc)
         4'd0: e.res = 0;
         4'd1: e.res = la;
         4'd2: e.res = lb;
         4'd3: e.res = la + lb;
         4'd4: e.res = la - lb;
         4'd5: e.res = la * lb;
         4'd6: if (lb == 0) e.err = 1'b1; else e.res = la / lb;
         4'd7: if (lb == 0) e.err = 1'b1; else e.res = la % lb;
         default: begin
            e     = '0;
            e.err = 1'b1;
         end
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_state(input string tag);
      tb_entry_t exp_head;
      exp_head = (sb.size() > 0) ? sb[0] : '0;
      check({tag, ".count"}, EW'(count), EW'(mcount));
      check({tag, ".valid"}, EW'(valid_out), EW'(mcount != 0));
      check({tag, ".full"},  EW'(full), EW'(mcount == DEPTH));
      check({tag, ".drop"},  EW'(drop_cnt), EW'(mdrop));
      check({tag, ".head"},  instruction_word, exp_head);
   endtask

   task automatic cycle(input string tag, input logic ld, input logic [3:0] opc,
                        input logic signed [31:0] a, input logic signed [31:0] b, input logic rd);
      bit do_pop;
      bit do_push;
      load_en   = ld;
      opcode    = opcode_t'(opc);
      operand_a = a;
      operand_b = b;
      rd_en     = rd;
      do_pop    = rd && (mcount > 0);
      do_push   = ld && ((mcount < DEPTH) || rd);
      if (ld && (mcount == DEPTH) && !rd && (mdrop < 65535)) mdrop++;
      @(posedge clk);
      #1;
      if (do_pop) begin
         void'(sb.pop_front());
         mcount--;
      end
      if (do_push) begin
         sb.push_back(model(opc, a, b));
         mcount++;
      end
      load_en = 1'b0;
      rd_en   = 1'b0;
      check_state(tag);
   endtask

   initial begin
      passed    = 0;
      total     = 0;
      mcount    = 0;
      mdrop     = 0;
      reset_n   = 1'b0;
      load_en   = 1'b0;
      rd_en     = 1'b0;
      opcode    = ZERO;
      operand_a = '0;
      operand_b = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      reset_n = 1'b1;

      // ADD 5 + -7
      cycle("add", 1'b1, 4'd3, 32'sd5, -32'sd7, 1'b0);
      h = instruction_word;
      check("add.res", {69'd0, h.res}, {69'd0, 64'hFFFF_FFFF_FFFF_FFFE});
      check("add.err", EW'(h.err), EW'(0));
      cycle("add_pop", 1'b0, 4'd0, 0, 0, 1'b1);

      // MULT full product
      cycle("mult", 1'b1, 4'd5, 32'sh7FFF_FFFF, 32'sd2, 1'b0);
      h = instruction_word;
      check("mult.res", {69'd0, h.res}, {69'd0, 64'h0000_0000_FFFF_FFFE});
      cycle("mult_pop", 1'b0, 4'd0, 0, 0, 1'b1);

      // DIV by zero, then MOD with negative dividend
      cycle("div0", 1'b1, 4'd6, 32'sd9, 32'sd0, 1'b0);
      cycle("mod", 1'b1, 4'd7, -32'sd7, 32'sd2, 1'b0);
      h = instruction_word;
      check("div0.res", {69'd0, h.res}, '0);
      check("div0.err", EW'(h.err), EW'(1));
      cycle("div0_pop", 1'b0, 4'd0, 0, 0, 1'b1);
      h = instruction_word;
      check("mod.res", {69'd0, h.res}, {69'd0, 64'hFFFF_FFFF_FFFF_FFFF});
      check("mod.err", EW'(h.err), EW'(0));
      cycle("mod_pop", 1'b0, 4'd0, 0, 0, 1'b1);

      // Illegal opcode stores a sanitised entry with only err set
      cycle("illegal", 1'b1, 4'd9, 32'sd3, 32'sd4, 1'b0);
      check("illegal.word", instruction_word, EW'(1));
      cycle("illegal_pop", 1'b0, 4'd0, 0, 0, 1'b1);

      // Overfill: DEPTH+3 pushes without pops
      for (int i = 0; i < DEPTH + 3; i++)
         cycle("fill", 1'b1, 4'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 4)) - 32'sd2, 1'b0);
      check("fill.drop3", EW'(drop_cnt), EW'(3));
      check("fill.full", EW'(full), EW'(1));

      // Push and pop together while full, across pointer wrap
      for (int i = 0; i < 2 * DEPTH; i++)
         cycle("wrap", 1'b1, 4'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 4)) - 32'sd2, 1'b1);
      check("wrap.count", EW'(count), EW'(DEPTH));

      // Drain in order
      for (int i = 0; i < DEPTH; i++)
         cycle("drain", 1'b0, 4'd0, 0, 0, 1'b1);

      // Pop on empty is ignored; push+pop on empty accepts only the push
      cycle("pop_empty", 1'b0, 4'd0, 0, 0, 1'b1);
      cycle("pushpop_empty", 1'b1, 4'd4, 32'sd10, 32'sd3, 1'b1);
      check("pushpop_empty.count", EW'(count), EW'(1));

      // Asynchronous reset between edges with 4 entries held
      for (int i = 0; i < 3; i++)
         cycle("pre_rst", 1'b1, 4'd1, 32'(i + 1), 32'sd0, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst.word", instruction_word, '0);
      check("arst.valid", EW'(valid_out), EW'(0));
      check("arst.count", EW'(count), EW'(0));
      sb.delete();
      mcount = 0;
      mdrop  = 0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      check_state("arst_release");
      @(negedge clk);
      cycle("post_rst", 1'b1, 4'd3, 32'sd100, -32'sd1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
